// File: rtl/vx_tex_bilerp.sv
// Bilinear texture filter: horizontal lerp, then vertical lerp, then round and saturate.
// Input capture register plus three compute stages under one global stall enable.

module vx_tex_bilerp_lane #(
    parameter int CH_W   = 8,
    parameter int FRAC_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [3:0][CH_W-1:0] texels,
    input  logic [FRAC_W-1:0]    frac_u,
    input  logic [FRAC_W-1:0]    frac_v,
    output logic [CH_W-1:0]      result
);
    localparam int H = CH_W + FRAC_W + 2;
    localparam int V = CH_W + 2*FRAC_W + 3;
    localparam int R = V - 2*FRAC_W;
    localparam logic signed [V-1:0] RND = {{(V-1){1'b0}}, 1'b1} << (2*FRAC_W - 1);

    logic [3:0][CH_W-1:0] t_q;
    logic signed [H-1:0]  top_d, bot_d, top_q, bot_q;
    logic signed [V-1:0]  top_x, bot_x, v_x, acc_d, acc_q, rnd_sum;
    logic signed [R-1:0]  r;
    logic [CH_W-1:0]      sat_d;

    // a*2^F + (b-a)*w at full precision; operands widened before the subtract
    function automatic logic signed [H-1:0] hlerp(input logic [CH_W-1:0] a, b,
                                                  input logic [FRAC_W-1:0] w);
        logic signed [H-1:0] a_s, d_s, w_s;
        a_s = $signed({{(H-CH_W){1'b0}}, a});
        d_s = $signed({{(H-CH_W){1'b0}}, b}) - a_s;
        w_s = $signed({{(H-FRAC_W){1'b0}}, w});
        return (a_s <<< FRAC_W) + d_s * w_s;
    endfunction

    assign top_d = hlerp(t_q[0], t_q[1], frac_u);
    assign bot_d = hlerp(t_q[2], t_q[3], frac_u);

    assign top_x = {{(V-H){top_q[H-1]}}, top_q};
    assign bot_x = {{(V-H){bot_q[H-1]}}, bot_q};
    assign v_x   = {{(V-FRAC_W){1'b0}}, frac_v};
    assign acc_d = (top_x <<< FRAC_W) + (bot_x - top_x) * v_x;

    // Taking the upper bits of the rounded sum is the arithmetic shift by 2F
    assign rnd_sum = acc_q + RND;
    assign r       = rnd_sum[V-1:2*FRAC_W];

    always_comb begin
        sat_d = r[CH_W-1:0];
        if (r[R-1])
            sat_d = '0;
        else if (|r[R-2:CH_W])
            sat_d = '1;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            t_q   <= texels;
            top_q <= top_d;
            bot_q <= bot_d;
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            result <= '0;
        else if (en)
            result <= sat_d;
    end
endmodule

module vx_tex_bilerp #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 8,
    parameter int FRAC_W = 8,
    parameter int TAG_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [4*NUM_CH*CH_W-1:0] req_texels,
    input  logic [FRAC_W-1:0]        req_frac_u,
    input  logic [FRAC_W-1:0]        req_frac_v,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [NUM_CH*CH_W-1:0]   rsp_data,
    output logic [TAG_W-1:0]         rsp_tag,
    input  logic                     rsp_ready
);
    localparam int STAGES = 3;

    typedef struct packed {
        logic [FRAC_W-1:0] u;
        logic [FRAC_W-1:0] v;
        logic [TAG_W-1:0]  tag;
    } side_t;

    logic                         en;
    logic [STAGES:0]              vld_pipe;
    side_t                        side_q;
    logic [FRAC_W-1:0]            v1_q;
    logic [TAG_W-1:0]             tag1_q, tag2_q;
    logic [NUM_CH-1:0][CH_W-1:0]  lane_out;

    // Whole pipe freezes while the output is held; bubbles advance like data
    assign en        = !rsp_valid || rsp_ready;
    assign req_ready = en;
    assign rsp_valid = vld_pipe[STAGES];
    assign rsp_data  = lane_out;

    always_ff @(posedge clk) begin
        if (reset)
            vld_pipe <= '0;
        else if (en)
            vld_pipe <= {vld_pipe[STAGES-1:0], req_valid};
    end

    always_ff @(posedge clk) begin
        if (en) begin
            side_q <= '{u: req_frac_u, v: req_frac_v, tag: req_tag};
            v1_q   <= side_q.v;
            tag1_q <= side_q.tag;
            tag2_q <= tag1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rsp_tag <= '0;
        else if (en)
            rsp_tag <= tag2_q;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic [3:0][CH_W-1:0] lane_tx;
        for (genvar k = 0; k < 4; k++) begin : g_tx
            assign lane_tx[k] = req_texels[(k*NUM_CH+c)*CH_W +: CH_W];
        end
        vx_tex_bilerp_lane #(.CH_W(CH_W), .FRAC_W(FRAC_W)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .en     (en),
            .texels (lane_tx),
            .frac_u (side_q.u),
            .frac_v (v1_q),
            .result (lane_out[c])
        );
    end
endmodule

// File: tb/tb_vx_tex_bilerp.sv
// Randomized and directed bench for vx_tex_bilerp against an integer bilinear model.

module tb_vx_tex_bilerp;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 8;
    localparam int FRAC_W = 8;
    localparam int TAG_W  = 16;
    localparam int DW     = NUM_CH*CH_W;

    localparam logic [7:0] D_TX [5][4] = '{'{8'h80, 8'h80, 8'h80, 8'h80},
                                          '{8'h00, 8'hFF, 8'h00, 8'h00},
                                          '{8'h00, 8'hFF, 8'h00, 8'h00},
                                          '{8'h00, 8'h00, 8'h00, 8'hFF},
                                          '{8'h00, 8'h00, 8'h00, 8'hFF}};
    localparam logic [7:0] D_U [5] = '{8'h5A, 8'h80, 8'h00, 8'hFF, 8'h00};
    localparam logic [7:0] D_V [5] = '{8'hC3, 8'h00, 8'h00, 8'hFF, 8'h00};
    localparam logic [7:0] D_E [5] = '{8'h80, 8'h80, 8'h00, 8'hFD, 8'h00};

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     req_valid = 1'b0;
    logic [4*NUM_CH*CH_W-1:0] req_texels = '0;
    logic [FRAC_W-1:0]        req_frac_u = '0;
    logic [FRAC_W-1:0]        req_frac_v = '0;
    logic [TAG_W-1:0]         req_tag = '0;
    logic                     req_ready;
    logic                     rsp_valid;
    logic [DW-1:0]            rsp_data;
    logic [TAG_W-1:0]         rsp_tag;
    logic                     rsp_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    typedef logic [TAG_W+DW-1:0] rsp_t;
    rsp_t exp_q[$];
    rsp_t got_q[$];

    vx_tex_bilerp #(.NUM_CH(NUM_CH), .CH_W(CH_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_texels (req_texels),
        .req_frac_u (req_frac_u),
        .req_frac_v (req_frac_v),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    // Real-valued bilinear filter done with wide integers, rounded half up, clamped
    function automatic logic [DW-1:0] model(input logic [4*NUM_CH*CH_W-1:0] tx,
                                            input logic [FRAC_W-1:0] u, v);
        logic [DW-1:0] res;
        longint t[4];
        longint top, bot, acc, r, one, maxv;
        one  = 1;
        maxv = (one << CH_W) - 1;
        res  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < 4; k++)
                t[k] = longint'(tx[(k*NUM_CH+c)*CH_W +: CH_W]);
            top = t[0]*(one << FRAC_W) + (t[1]-t[0])*longint'(u);
            bot = t[2]*(one << FRAC_W) + (t[3]-t[2])*longint'(u);
            acc = top*(one << FRAC_W) + (bot-top)*longint'(v);
            r   = (acc + (one << (2*FRAC_W-1))) >>> (2*FRAC_W);
            if (r < 0) r = 0;
            if (r > maxv) r = maxv;
            res[c*CH_W +: CH_W] = CH_W'(r);
        end
        return res;
    endfunction

    function automatic logic [4*NUM_CH*CH_W-1:0] rep4(input logic [CH_W-1:0] a, b, c, d);
        return {{NUM_CH{d}}, {NUM_CH{c}}, {NUM_CH{b}}, {NUM_CH{a}}};
    endfunction

    // Records handshakes as they will land on the coming edge; reset cancels in-flight work
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready)
                got_q.push_back({rsp_tag, rsp_data});
            if (req_valid && req_ready) begin
                exp_q.push_back({req_tag, model(req_texels, req_frac_u, req_frac_v)});
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(input logic [TAG_W-1:0] tag);
        for (int i = 0; i < 4*NUM_CH; i++)
            req_texels[i*CH_W +: CH_W] = CH_W'($urandom);
        if ($urandom_range(0, 7) == 0)
            req_texels = {(4*NUM_CH){CH_W'($urandom_range(0, 1) != 0 ? '1 : '0)}};
        req_frac_u = FRAC_W'($urandom);
        req_frac_v = FRAC_W'($urandom);
        if ($urandom_range(0, 5) == 0) req_frac_u = '1;
        if ($urandom_range(0, 5) == 0) req_frac_v = '0;
        req_tag   = tag;
        req_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        tick(); tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", rsp_data); end
        checks++; if (rsp_tag !== '0) begin errors++; $display("FAIL reset_tag got %h exp 0", rsp_tag); end
        reset = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_directed();
        logic [DW-1:0] exp_d;
        int lat;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_texels = rep4(D_TX[i][0], D_TX[i][1], D_TX[i][2], D_TX[i][3]);
            req_frac_u = D_U[i];
            req_frac_v = D_V[i];
            req_tag    = TAG_W'(32'h100 + i);
            req_valid  = 1'b1;
            exp_d      = {NUM_CH{D_E[i]}};
            tick();
            req_valid = 1'b0;
            lat = 0;
            while (!rsp_valid && lat < 10) begin tick(); lat++; end
            checks++; if (lat !== 3) begin errors++; $display("FAIL dir%0d_latency got %0d exp 3", i, lat); end
            checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL dir%0d_data got %h exp %h", i, rsp_data, exp_d); end
            checks++; if (rsp_tag !== TAG_W'(32'h100 + i)) begin errors++; $display("FAIL dir%0d_tag got %h exp %h", i, rsp_tag, 32'h100 + i); end
            tick();
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        int first, last, cnt;
        rsp_t g, e;
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b1;
        first = -1; last = -1; cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 8) rand_req(TAG_W'(cyc + 1));
            else req_valid = 1'b0;
            tick();
            if (rsp_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                cnt++;
            end
        end
        checks++; if (cnt !== 8 || last - first !== 7) begin errors++; $display("FAIL b2b_contiguous got %0d valid over %0d cycles exp 8 over 8", cnt, last - first + 1); end
        checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", got_q.size()); end
        for (int i = 0; i < 8 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e || g[TAG_W+DW-1:DW] !== TAG_W'(i + 1)) begin errors++; $display("FAIL b2b_rsp%0d got %h exp %h", i, g, e); end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] hold_d;
        logic [TAG_W-1:0] hold_t;
        int k, a0;
        rsp_t g, e;
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin rand_req(TAG_W'(32'h200 + i)); tick(); end
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 10) begin tick(); k++; end
        checks++; if (rsp_tag !== TAG_W'(32'h200)) begin errors++; $display("FAIL stall_head_tag got %h exp 200", rsp_tag); end
        hold_d = rsp_data; hold_t = rsp_tag;
        rand_req(TAG_W'(32'h203));
        for (int i = 0; i < 5; i++) begin
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %b exp 0", i, req_ready); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== hold_d || rsp_tag !== hold_t) begin
                errors++; $display("FAIL stall_hold%0d got %b/%h/%h exp 1/%h/%h", i, rsp_valid, rsp_data, rsp_tag, hold_d, hold_t);
            end
        end
        rsp_ready = 1'b1;
        a0 = n_acc; k = 0;
        while (n_acc == a0 && k < 10) begin tick(); k++; end
        req_valid = 1'b0;
        repeat (8) tick();
        checks++; if (got_q.size() !== 4 || exp_q.size() !== 4) begin errors++; $display("FAIL stall_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e || g[TAG_W+DW-1:DW] !== TAG_W'(32'h200 + i)) begin errors++; $display("FAIL stall_rsp%0d got %h exp %h", i, g, e); end
        end
    endtask

    task automatic test_reset_flush();
        logic [DW-1:0] exp_d;
        int seen, lat;
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin rand_req(TAG_W'(32'h300 + i)); tick(); end
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_tag !== '0) begin
            errors++; $display("FAIL flush_clear got %b/%h/%h exp 0/0/0", rsp_valid, rsp_data, rsp_tag);
        end
        seen = 0;
        repeat (6) begin tick(); if (rsp_valid) seen++; end
        checks++; if (seen !== 0 || got_q.size() !== 0) begin errors++; $display("FAIL flush_ghost got %0d responses exp 0", seen + got_q.size()); end
        rand_req(TAG_W'(32'h302));
        exp_d = model(req_texels, req_frac_u, req_frac_v);
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin tick(); lat++; end
        checks++; if (lat !== 3) begin errors++; $display("FAIL flush_latency got %0d exp 3", lat); end
        checks++; if (rsp_data !== exp_d || rsp_tag !== TAG_W'(32'h302)) begin
            errors++; $display("FAIL flush_after got %h/%h exp %h/302", rsp_data, rsp_tag, exp_d);
        end
        tick();
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        int a0, nexp;
        logic [TAG_W-1:0] tag;
        rsp_t g, e;
        exp_q.delete(); got_q.delete();
        tag = '0;
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!req_valid && $urandom_range(0, 9) < 7) begin
                tag = tag + 1'b1;
                rand_req(tag);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            a0 = n_acc;
            tick();
            if (n_acc != a0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) tick();
        nexp = exp_q.size();
        checks++; if (got_q.size() !== nexp || nexp < 100) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), nexp); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL rand_rsp got %h exp %h", g, e); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
